pll_reset_seq: RTL and testbench

Reset and clock-enable sequencer driven by the system PLL. It runs on the 28.636360 MHz PLL output and brings the asynchronous PLL `locked` flag into that domain. It holds the core in reset until lock has been continuously stable, then releases reset and generates the CPU-rate clock enable. It also detects and counts loss-of-lock events for debug and OSD reporting.

---
 rtl/pll_reset_seq.sv | 129 ++++++++++++
 tb/tb_pll_reset_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// PLL lock synchronizer and reset sequencer. Holds the core in reset until lock
// has been continuously stable, then generates the CPU clock enable and counts lock losses.
//
//   state     | meaning
//   WAIT_LOCK | waiting for synchronized lock, stab_cnt held at 0
//   STABILIZE | counting consecutive locked cycles
//   RELEASE   | one-cycle handoff, divider cleared
//   RUN       | core out of reset, ce_cpu running
module pll_reset_seq #(
    parameter int STABLE_CYCLES = 1024,
    parameter int DIV           = 8,
    parameter int LOSS_W        = 8
) (
    input  logic                    clk_sys,
    input  logic                    rst,
    input  logic                    locked,
    input  logic                    loss_clr,
    output logic                    sys_reset,
    output logic                    ready,
    output logic                    ce_cpu,
    output logic [$clog2(DIV)-1:0]  div_phase,
    output logic [LOSS_W-1:0]       loss_count,
    output logic                    loss_sticky
);
    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int DIV_W  = $clog2(DIV);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [LOSS_W-1:0] LOSS_MAX  = '1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic                sync_q1, locked_s;
    logic [STAB_W-1:0]   stab_cnt, stab_cnt_nxt;
    logic [DIV_W-1:0]    div_cnt, div_cnt_nxt;
    logic                loss_evt;
    logic [LOSS_W-1:0]   loss_count_nxt;
    logic                loss_sticky_nxt;
    logic                sys_reset_q;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            sync_q1  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_q1  <= locked;
            locked_s <= sync_q1;
        end
    end

    always_comb begin
        state_nxt    = state;
        stab_cnt_nxt = '0;
        div_cnt_nxt  = '0;
        loss_evt     = 1'b0;
        unique case (state)
            WAIT_LOCK: begin
                if (locked_s) state_nxt = STABILIZE;
            end
            STABILIZE: begin
                if (!locked_s)
                    state_nxt = WAIT_LOCK;
                else if (stab_cnt == STAB_LAST)
                    state_nxt = RELEASE;
                else
                    stab_cnt_nxt = stab_cnt + 1'b1;
            end
            RELEASE: begin
                state_nxt = locked_s ? RUN : WAIT_LOCK;
            end
            RUN: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    loss_evt  = 1'b1;
                end else begin
                    // explicit wrap so non-power-of-two ratios work
                    div_cnt_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
                end
            end
            default: state_nxt = WAIT_LOCK;
        endcase
    end

    // a loss on the same edge as a clear wins, so it is counted from zero
    always_comb begin
        loss_count_nxt  = loss_count;
        loss_sticky_nxt = loss_sticky;
        if (loss_evt) begin
            loss_sticky_nxt = 1'b1;
            if (loss_clr)
                loss_count_nxt = {{(LOSS_W-1){1'b0}}, 1'b1};
            else if (loss_count != LOSS_MAX)
                loss_count_nxt = loss_count + 1'b1;
        end else if (loss_clr) begin
            loss_count_nxt  = '0;
            loss_sticky_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state       <= WAIT_LOCK;
            stab_cnt    <= '0;
            div_cnt     <= '0;
            sys_reset_q <= 1'b1;
            loss_count  <= '0;
            loss_sticky <= 1'b0;
        end else begin
            state       <= state_nxt;
            stab_cnt    <= stab_cnt_nxt;
            div_cnt     <= div_cnt_nxt;
            sys_reset_q <= (state_nxt != RUN);
            loss_count  <= loss_count_nxt;
            loss_sticky <= loss_sticky_nxt;
        end
    end

    assign sys_reset = sys_reset_q;
    assign ready     = (state == RUN);
    assign ce_cpu    = (state == RUN) && (div_cnt == DIV_LAST);
    assign div_phase = div_cnt;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: a consecutive-lock-count model checked every cycle,
// plus directed scenarios with hand-computed edge counts and counter values.
module tb_pll_reset_seq;
    localparam int SC  = 16;
    localparam int DIV = 8;
    localparam int LW  = 8;

    logic       clk_sys = 1'b0;
    logic       rst = 1'b0;
    logic       locked = 1'b0;
    logic       loss_clr = 1'b0;
    logic       sys_reset, ready, ce_cpu, loss_sticky;
    logic [2:0] div_phase;
    logic [7:0] loss_count;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    pll_reset_seq #(.STABLE_CYCLES(SC), .DIV(DIV), .LOSS_W(LW)) dut (
        .clk_sys(clk_sys), .rst(rst), .locked(locked), .loss_clr(loss_clr),
        .sys_reset(sys_reset), .ready(ready), .ce_cpu(ce_cpu),
        .div_phase(div_phase), .loss_count(loss_count), .loss_sticky(loss_sticky)
    );

    always #5 clk_sys = ~clk_sys;

    // Model: the design is in RUN once the synchronized lock has been seen high
    // on SC+2 consecutive edges; any low sample drops it back to zero.
    logic m_s1, m_s2;
    int   m_streak;
    int   m_loss;
    logic m_sticky;

    always @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            m_s1 <= 1'b0; m_s2 <= 1'b0; m_streak <= 0; m_loss <= 0; m_sticky <= 1'b0;
        end else begin
            m_s1 <= locked;
            m_s2 <= m_s1;
            m_streak <= m_s2 ? m_streak + 1 : 0;
            if (m_streak >= SC + 2 && !m_s2) begin
                m_loss   <= loss_clr ? 1 : ((m_loss >= (1 << LW) - 1) ? m_loss : m_loss + 1);
                m_sticky <= 1'b1;
            end else if (loss_clr) begin
                m_loss   <= 0;
                m_sticky <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: actual %0d required %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        bit run;
        int ph;
        if (cmp_en) begin
            run = (m_streak >= SC + 2);
            ph  = run ? (m_streak - SC - 2) % DIV : 0;
            check("cyc_sys_reset", int'(sys_reset), int'(!run));
            check("cyc_ready", int'(ready), int'(run));
            check("cyc_ce_cpu", int'(ce_cpu), int'(run && ph == DIV - 1));
            check("cyc_div_phase", int'(div_phase), ph);
            check("cyc_loss_count", int'(loss_count), m_loss);
            check("cyc_loss_sticky", int'(loss_sticky), int'(m_sticky));
        end
    end

    // counts edges until sys_reset reaches lvl, sampled 1 time unit after each edge
    task automatic wait_level(input string name, input logic lvl, input int exp_edges);
        int n;
        n = 0;
        do begin
            @(posedge clk_sys); #1;
            n++;
        end while (sys_reset !== lvl && n < 200);
        check(name, n, exp_edges);
    endtask

    task automatic do_loss();
        @(negedge clk_sys) locked = 1'b0;
        wait_level("loss_edges", 1'b1, 3);
        @(negedge clk_sys) locked = 1'b1;
        wait_level("relock_edges", 1'b0, 20);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sys_reset"}, int'(sys_reset), 1);
        check({tag, "_ready"}, int'(ready), 0);
        check({tag, "_ce_cpu"}, int'(ce_cpu), 0);
        check({tag, "_div_phase"}, int'(div_phase), 0);
        check({tag, "_loss_count"}, int'(loss_count), 0);
        check({tag, "_loss_sticky"}, int'(loss_sticky), 0);
    endtask

    initial begin
        int n;
        #1 rst = 1'b1;
        #1 check_reset_vals("por");
        repeat (3) @(negedge clk_sys);
        rst = 1'b0;
        cmp_en = 1'b1;

        // lock glitch at stab_cnt = 10, then a full window again
        @(negedge clk_sys) locked = 1'b1;
        repeat (13) @(posedge clk_sys);
        @(negedge clk_sys) locked = 1'b0;
        repeat (4) @(negedge clk_sys);
        locked = 1'b1;
        wait_level("glitch_relock_edges", 1'b0, 20);
        check("glitch_loss_count", int'(loss_count), 0);
        check("glitch_loss_sticky", int'(loss_sticky), 0);

        // first ce_cpu in RUN cycle 8, then every 8 cycles
        n = 1;
        while (!ce_cpu && n < 50) begin @(posedge clk_sys); #1; n++; end
        check("ce_first_cycle", n, 8);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin @(posedge clk_sys); #1; n++; end while (!ce_cpu && n < 50);
            check("ce_period", n, 8);
        end

        // loss in RUN
        @(negedge clk_sys) locked = 1'b0;
        wait_level("run_loss_edges", 1'b1, 3);
        check("run_loss_ce", int'(ce_cpu), 0);
        check("run_loss_count", int'(loss_count), 1);
        check("run_loss_sticky", int'(loss_sticky), 1);
        @(negedge clk_sys) locked = 1'b1;
        wait_level("run_relock_edges", 1'b0, 20);
        check("run_relock_count", int'(loss_count), 1);

        // clear coinciding with a loss, starting from 5
        repeat (4) do_loss();
        check("pre_coincide_count", int'(loss_count), 5);
        @(negedge clk_sys) locked = 1'b0;
        @(posedge clk_sys);
        @(posedge clk_sys);
        @(negedge clk_sys) loss_clr = 1'b1;
        @(posedge clk_sys); #1;
        check("coincide_sys_reset", int'(sys_reset), 1);
        check("coincide_count", int'(loss_count), 1);
        check("coincide_sticky", int'(loss_sticky), 1);
        @(negedge clk_sys) loss_clr = 1'b0;
        locked = 1'b1;
        wait_level("coincide_relock_edges", 1'b0, 20);

        // saturation
        repeat (300) do_loss();
        check("sat_count", int'(loss_count), 255);
        check("sat_sticky", int'(loss_sticky), 1);
        @(negedge clk_sys) loss_clr = 1'b1;
        @(negedge clk_sys) loss_clr = 1'b0;
        check("clr_count", int'(loss_count), 0);
        check("clr_sticky", int'(loss_sticky), 0);
        check("clr_still_ready", int'(ready), 1);

        // asynchronous reset between edges while in RUN
        repeat (5) @(posedge clk_sys);
        #2 rst = 1'b1;
        #1 check_reset_vals("async");
        @(negedge clk_sys) rst = 1'b0;
        wait_level("post_rst_edges", 1'b0, 20);

        repeat (10) @(negedge clk_sys);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
